// File: rtl/sp_ram_arb_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
package sp_ram_arb_pkg;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    localparam int unsigned MEM_WORDS_DEFAULT = 256;

    // A byte address is in range when no bit above the word index is set.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned addr_w);
        logic [31:0] hi;
        hi = addr >> (addr_w + 2);
        return hi == '0;
    endfunction

endpackage

// File: rtl/sp_ram_arbiter_if.sv
// Fetch, LSU and RAM port bundle seen by the arbiter.
interface sp_ram_arbiter_if;
    logic        instr_req_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_addr_i;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;

    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    logic        ram_req_o;
    logic        ram_gnt_i;
    logic        ram_rvalid_i;
    logic [31:0] ram_addr_o;
    logic        ram_we_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;

    // Arbiter side.
    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output ram_req_o, ram_addr_o, ram_we_o, ram_wdata_o,
        input  ram_gnt_i, ram_rvalid_i, ram_rdata_i
    );

    // Core and RAM side.
    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  ram_req_o, ram_addr_o, ram_we_o, ram_wdata_o,
        output ram_gnt_i, ram_rvalid_i, ram_rdata_i
    );
endinterface

// File: rtl/sp_ram_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; bit 0 = fetch, bit 1 = LSU.
module rr_arb2
    import sp_ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] win
);

    owner_e prio_q, prio_d;

    // Pick the winner; on a grant the other master takes priority for the next conflict.
    always_comb begin
        win    = 2'b00;
        prio_d = prio_q;
        unique case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = (prio_q == OWN_DATA) ? 2'b10 : 2'b01;
            default: win = 2'b00;
        endcase
        if (advance && win[1]) begin
            prio_d = OWN_INSTR;
        end else if (advance && win[0]) begin
            prio_d = OWN_DATA;
        end
    end

    // Priority register, data wins the first conflict after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= OWN_DATA;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Fetch/LSU front end for the single-port RAM: arbitration, byte merge, registered response.
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter int unsigned ADDR_W    = $clog2(MEM_WORDS)
) (
    input logic               clk,
    input logic               rst_n,
    sp_ram_arbiter_if.slave   bus
);

    localparam logic [31:0] IDX_MASK = 32'((64'd1 << ADDR_W) - 64'd1);

    logic [1:0]  win;
    logic        win_data, win_any, win_in_range;
    logic        instr_in_range, data_in_range;
    logic [31:0] win_addr;
    logic        instr_gnt, data_gnt, any_gnt;
    logic [31:0] rsp_rdata;

    logic        pend_q, pend_oor_q;
    owner_e      owner_q;
    logic [31:0] instr_rdata_q, data_rdata_q;
    logic        instr_err_q, data_err_q;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({bus.data_req_i, bus.instr_req_i}),
        .advance (any_gnt),
        .win     (win)
    );

    // Grant, RAM request and read-modify-write data for the current winner.
    always_comb begin
        instr_in_range = addr_in_range(bus.instr_addr_i, ADDR_W);
        data_in_range  = addr_in_range(bus.data_addr_i, ADDR_W);
        win_data       = win[1];
        win_any        = |win;
        win_addr       = win_data ? bus.data_addr_i : bus.instr_addr_i;
        win_in_range   = win_data ? data_in_range : instr_in_range;

        // Out-of-range accesses never touch the RAM, so they need no RAM grant.
        instr_gnt = win[0] && (bus.ram_gnt_i || !instr_in_range);
        data_gnt  = win[1] && (bus.ram_gnt_i || !data_in_range);
        any_gnt   = instr_gnt || data_gnt;

        bus.instr_gnt_o = instr_gnt;
        bus.data_gnt_o  = data_gnt;
        bus.ram_req_o   = win_any && win_in_range;
        bus.ram_addr_o  = (win_addr >> 2) & IDX_MASK;
        bus.ram_we_o    = data_gnt && bus.data_we_i && data_in_range;

        for (int k = 0; k < 4; k++) begin
            bus.ram_wdata_o[8*k +: 8] = bus.data_be_i[k] ? bus.data_wdata_i[8*k +: 8]
                                                         : bus.ram_rdata_i[8*k +: 8];
        end

        // Only in-range reads return RAM data; writes and errors return zero.
        rsp_rdata = (win_in_range && !(win_data && bus.data_we_i)) ? bus.ram_rdata_i : '0;
    end

    // Capture the response at grant; it becomes visible with rvalid one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q        <= 1'b0;
            pend_oor_q    <= 1'b0;
            owner_q       <= OWN_DATA;
            instr_rdata_q <= '0;
            instr_err_q   <= 1'b0;
            data_rdata_q  <= '0;
            data_err_q    <= 1'b0;
        end else begin
            pend_q <= any_gnt;
            if (any_gnt) begin
                pend_oor_q <= !win_in_range;
                owner_q    <= win_data ? OWN_DATA : OWN_INSTR;
            end
            if (instr_gnt) begin
                instr_rdata_q <= rsp_rdata;
                instr_err_q   <= !win_in_range;
            end
            if (data_gnt) begin
                data_rdata_q <= rsp_rdata;
                data_err_q   <= !win_in_range;
            end
        end
    end

    // Route the response to its owner only.
    always_comb begin
        bus.instr_rvalid_o = pend_q && (pend_oor_q || bus.ram_rvalid_i) && (owner_q == OWN_INSTR);
        bus.data_rvalid_o  = pend_q && (pend_oor_q || bus.ram_rvalid_i) && (owner_q == OWN_DATA);
        bus.instr_rdata_o  = instr_rdata_q;
        bus.instr_err_o    = instr_err_q;
        bus.data_rdata_o   = data_rdata_q;
        bus.data_err_o     = data_err_q;
    end

endmodule
